// File: rtl/kanagawa_lfsr_pkg.sv
// Shared polynomial definition for the Kanagawa 11-bit XNOR LFSR (taps 11 and 9).
// Latency: n/a (constants, types and a combinational helper function).
// Backpressure: n/a. Used by both the generator and kanagawa_lfsr_checker.
package kanagawa_lfsr_pkg;

  localparam int LFSR_WIDTH = 11;
  // Zero-based bit positions of polynomial taps 11 and 9.
  localparam int TAP_HI     = 10;
  localparam int TAP_LO     = 8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Next generator word: shift left, XNOR feedback enters at bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next_word(input logic [LFSR_WIDTH-1:0] prev);
    return {prev[LFSR_WIDTH-2:0], ~(prev[TAP_HI] ^ prev[TAP_LO])};
  endfunction

endpackage

// File: rtl/kanagawa_lfsr_checker.sv
// Receive-side LFSR checker: predicts each sample from the previous one, locks, counts errors.
// Latency: outputs update on the edge that consumes a sample (visible next cycle).
// Backpressure: none; sample_valid qualifies input, idle cycles hold all state.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   sample_valid    sample present this cycle
//   sample          generator word (WIDTH bits)
//   clr_err         synchronous clear of err_count, lock_lost (and lockup)
//   locked          checker is in LOCKED state
//   err_pulse       one-cycle pulse per counted mismatch
//   err_count       saturating mismatch count (counted only while LOCKED)
//   lock_lost       sticky: lock dropped since last clr_err/reset
//   lockup          sticky all-ones detector; only active when
//                   KANAGAWA_LFSR_CHECKER_LOCKUP_DETECT_EN is defined, else tied 0
module kanagawa_lfsr_checker
  import kanagawa_lfsr_pkg::*;
#(
  parameter int WIDTH      = 11,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             lock_lost,
  output logic             lockup
);

  if (WIDTH != LFSR_WIDTH) begin : g_width_chk
    $fatal(1, "kanagawa_lfsr_checker: only WIDTH=11 is supported");
  end
  if (LOCK_COUNT < 1 || LOSS_COUNT < 1) begin : g_count_chk
    $fatal(1, "kanagawa_lfsr_checker: LOCK_COUNT and LOSS_COUNT must be >= 1");
  end

  // Run counters must hold values up to the larger threshold.
  localparam int RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT + 1 : LOSS_COUNT + 1;
  localparam int RUN_W   = $clog2(RUN_MAX);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] bad_run;

  logic [WIDTH-1:0] expected;
  logic             compare;
  logic             same;
  logic             match;
  logic             mismatch;
  logic [CNT_W-1:0] err_base;
  logic [CNT_W-1:0] err_next;

  assign expected = lfsr_next_word(prev);
  assign compare  = sample_valid & prev_valid;

`ifdef KANAGAWA_LFSR_CHECKER_LOCKUP_DETECT_EN
  // All-ones is the XNOR lockup fixed point; never accept it as a match.
  assign same = (sample == expected) & ~(&sample);
`else
  assign same = (sample == expected);
`endif

  assign match    = compare & same;
  assign mismatch = compare & ~same;

  // Clear takes effect before the increment of the same cycle.
  assign err_base = clr_err ? '0 : err_count;
  assign err_next = (&err_base) ? err_base : err_base + CNT_W'(1);

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      prev       <= '0;
      prev_valid <= 1'b0;
      good_run   <= '0;
      bad_run    <= '0;
      err_count  <= '0;
      err_pulse  <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;

      if (clr_err) begin
        err_count <= '0;
        lock_lost <= 1'b0;
      end

      // Always resynchronise to the received word, good or bad.
      if (sample_valid) begin
        prev       <= sample;
        prev_valid <= 1'b1;
      end

      case (state)
        SEARCH: begin
          if (match) begin
            if (good_run == RUN_W'(LOCK_COUNT - 1)) begin
              state    <= LOCKED;
              good_run <= '0;
              bad_run  <= '0;
            end else begin
              good_run <= good_run + RUN_W'(1);
            end
          end else if (mismatch) begin
            good_run <= '0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_run <= '0;
          end else if (mismatch) begin
            err_count <= err_next;
            err_pulse <= 1'b1;
            if (bad_run == RUN_W'(LOSS_COUNT - 1)) begin
              state     <= SEARCH;
              good_run  <= '0;
              bad_run   <= '0;
              lock_lost <= 1'b1;
            end else begin
              bad_run <= bad_run + RUN_W'(1);
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef KANAGAWA_LFSR_CHECKER_LOCKUP_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lockup <= 1'b0;
    end else if (sample_valid && (&sample)) begin
      lockup <= 1'b1;
    end else if (clr_err) begin
      lockup <= 1'b0;
    end
  end
`else
  assign lockup = 1'b0;
`endif

endmodule

// File: tb/tb_kanagawa_lfsr_checker.sv
// Self-checking bench for kanagawa_lfsr_checker (16-bit and 4-bit counter builds side by side).
// Latency: outputs checked on every falling edge against a behavioural model.
// Backpressure: n/a; directed sample stream with idle gaps.
module tb_kanagawa_lfsr_checker;

`ifdef KANAGAWA_LFSR_CHECKER_LOCKUP_DETECT_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [10:0] sample = '0;
  logic        clr_err = 1'b0;

  logic        locked, err_pulse, lock_lost, lockup;
  logic [15:0] err_count;
  logic        locked4, err_pulse4, lock_lost4, lockup4;
  logic [3:0]  err_count4;

  kanagawa_lfsr_checker dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .lock_lost(lock_lost), .lockup(lockup)
  );

  kanagawa_lfsr_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample), .clr_err(clr_err),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4),
    .lock_lost(lock_lost4), .lockup(lockup4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Generator polynomial in plain arithmetic: shift left mod 2^11, add XNOR of bits 10 and 8.
  function automatic int nx(input int p);
    return ((p * 2) % 2048) + ((((p / 1024) % 2) == ((p / 256) % 2)) ? 1 : 0);
  endfunction

  // ---------------- behavioural model ----------------
  int m_prev = 0;
  bit m_pv = 0, m_locked = 0, m_pulse = 0, m_lost = 0, m_lockup = 0;
  int m_good = 0, m_bad = 0, m_cnt16 = 0, m_cnt4 = 0;
  int ms;
  bit meq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 0; m_pv = 0; m_locked = 0; m_pulse = 0; m_lost = 0; m_lockup = 0;
      m_good = 0; m_bad = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      m_pulse = 0;
      if (clr_err) begin
        m_cnt16 = 0; m_cnt4 = 0; m_lost = 0; m_lockup = 0;
      end
      if (sample_valid) begin
        ms = int'(sample);
        if (m_pv) begin
          meq = (ms == nx(m_prev)) && !(LK && ms == 2047);
          if (!m_locked) begin
            if (meq) begin
              m_good++;
              if (m_good == 8) begin m_locked = 1; m_good = 0; m_bad = 0; end
            end else m_good = 0;
          end else begin
            if (meq) m_bad = 0;
            else begin
              m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
              m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
              m_pulse = 1;
              m_bad++;
              if (m_bad == 4) begin m_locked = 0; m_good = 0; m_bad = 0; m_lost = 1; end
            end
          end
        end
        if (LK && ms == 2047) m_lockup = 1;
        m_prev = ms;
        m_pv = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("locked", locked, m_locked);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_count", err_count, m_cnt16);
    chk("lock_lost", lock_lost, m_lost);
    chk("lockup", lockup, m_lockup);
    chk("locked4", locked4, m_locked);
    chk("err_pulse4", err_pulse4, m_pulse);
    chk("err_count4", err_count4, m_cnt4);
    chk("lock_lost4", lock_lost4, m_lost);
    if (err_pulse === 1'b1) pulse_cnt++;
  end

  // ---------------- stimulus ----------------
  logic [10:0] g;

  task automatic send(input logic [10:0] d, input logic c);
    @(negedge clk);
    sample_valid = 1'b1;
    sample = d;
    clr_err = c;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clr_err = 1'b0;
    sample = 11'($urandom);
  endtask

  task automatic clean(input logic c);
    g = 11'(nx(int'(g)));
    send(g, c);
  endtask

  // Off-sequence word: generator advances, bit 6 flipped on the wire.
  task automatic garbage(input logic c);
    g = 11'(nx(int'(g)));
    send(g ^ 11'h040, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample = 11'($urandom);
    end
  endtask

  logic [10:0] tv1 [9] = '{11'h001, 11'h003, 11'h007, 11'h00F, 11'h01F,
                           11'h03F, 11'h07F, 11'h0FF, 11'h1FF};
  int p0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_lock_lost", lock_lost, 0);
    @(negedge clk);
    rst = 1'b0;

    // Pin the model's polynomial against hand-computed words.
    for (int i = 0; i < 8; i++) chk("model_nx_tab", nx(int'(tv1[i])), int'(tv1[i+1]));
    chk("model_nx_1ff", nx(11'h1FF), 11'h3FE);
    chk("model_nx_7fc", nx(11'h7FC), 11'h7F9);
    chk("model_nx_7ff", nx(11'h7FF), 11'h7FF);

    // 1: clean sequence, lock after 8 matches
    for (int i = 0; i < 9; i++) begin
      send(tv1[i], 1'b0);
      if (i == 7) chk("t1_not_yet_locked", locked, 0);
    end
    chk("t1_locked", locked, 1);
    chk("t1_err_count", err_count, 0);
    g = tv1[8];

    // 2: single corrupted word -> two counted mismatches, lock kept
    p0 = pulse_cnt;
    clean(1'b0);
    chk("t2_seq_3fe", g, 11'h3FE);
    clean(1'b0);
    g = 11'(nx(int'(g)));
    send(11'h000, 1'b0);
    clean(1'b0);
    clean(1'b0);
    @(negedge clk); #1;
    chk("t2_pulses", pulse_cnt - p0, 2);
    chk("t2_err_count", err_count, 2);
    chk("t2_locked", locked, 1);

    // 3: four consecutive bad words drop lock, then re-lock
    garbage(1'b0); garbage(1'b0); garbage(1'b0);
    chk("t3_locked_after3", locked, 1);
    garbage(1'b0);
    chk("t3_locked_after4", locked, 0);
    chk("t3_lock_lost", lock_lost, 1);
    chk("t3_err_count", err_count, 6);
    repeat (8) clean(1'b0);
    chk("t3_not_relocked", locked, 0);
    clean(1'b0);
    chk("t3_relocked", locked, 1);

    // 4: saturate the 4-bit counter
    p0 = pulse_cnt;
    repeat (6) begin
      garbage(1'b0); clean(1'b0); clean(1'b0);
    end
    @(negedge clk); #1;
    chk("t4_cnt4_sat", err_count4, 4'hF);
    chk("t4_cnt16", err_count, 18);
    chk("t4_pulses", pulse_cnt - p0, 12);
    chk("t4_locked", locked, 1);

    // 5: clr_err on a counted mismatch, clr with loss, idle gaps
    clean(1'b0);
    garbage(1'b1);
    chk("t5_clr_inc", err_count, 1);
    chk("t5_clr_inc4", err_count4, 1);
    chk("t5_lost_cleared", lock_lost, 0);
    clean(1'b0);
    chk("t5_successor", err_count, 2);
    clean(1'b0);
    garbage(1'b0); garbage(1'b0); garbage(1'b0);
    garbage(1'b1);
    chk("t5_clr_loss_cnt", err_count, 1);
    chk("t5_clr_loss_lost", lock_lost, 1);
    chk("t5_clr_loss_locked", locked, 0);
    @(negedge clk); clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    chk("t5_clr_only_lost", lock_lost, 0);
    chk("t5_clr_only_cnt", err_count, 0);
    for (int i = 0; i < 9; i++) begin
      clean(1'b0);
      idle(2);
    end
    chk("t5_gap_locked", locked, 1);
    chk("t5_gap_cnt", err_count, 0);

    // 6: async reset mid-LOCKED, then all-ones stream
    garbage(1'b0);
    chk("t6_pre_rst_cnt", err_count, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_cnt", err_count, 0);
    chk("t6_rst_pulse", err_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(11'h7FF, 1'b0);
      if (i == 8) chk("t6_ones_locked", locked, LK ? 0 : 1);
    end
    chk("t6_lockup", lockup, LK ? 1 : 0);
    chk("t6_ones_locked4", locked4, LK ? 0 : 1);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
